main_memory_responder: RTL and testbench

MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

---
 rtl/main_memory_responder.sv | 144 ++++++++++++++
 tb/tb_main_memory_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - shared byte-array memory serving an I-cache and a D-cache port
// Optional round-robin tie arbitration: MEM_RR_ARB_EN (default is fixed D-cache priority).
module main_memory_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_LEN   = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_cache_mem_vis_signal,
  input  logic [ADDR_WIDTH-1:0] i_cache_mem_vis_addr,
  input  logic [1:0]            d_cache_mem_vis_signal,
  input  logic [ADDR_WIDTH-1:0] d_cache_mem_vis_addr,
  input  logic [2:0]            data_type,
  input  logic [DATA_LEN-1:0]   written_data,
  output logic [DATA_LEN-1:0]   i_mem_data,
  output logic [1:0]            i_mem_status,
  output logic [DATA_LEN-1:0]   d_mem_data,
  output logic [1:0]            d_mem_status
);

  localparam int NBYTES = DATA_LEN / BYTE_SIZE;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                state, state_next;
  logic [3:0]            count;
  logic                  grant_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            type_q;
  logic [DATA_LEN-1:0]   wdata_q;
  logic [DATA_LEN-1:0]   rdata;
  logic [BYTE_SIZE-1:0]  mem [0:(2**ADDR_WIDTH)-1];
  int                    wr_bytes;

  logic i_valid, d_read, d_write, d_valid, accept, op, pick_d;

  assign i_valid = (i_cache_mem_vis_signal == 2'b01);
  assign d_read  = (d_cache_mem_vis_signal == 2'b01);
  assign d_write = (d_cache_mem_vis_signal == 2'b10);
  assign d_valid = d_read | d_write;
  assign accept  = (state == S_IDLE) && (i_valid || d_valid);
  assign op      = (state == S_ACCESS) && (count == 4'd0);

`ifdef MEM_RR_ARB_EN
  // Pointer remembers the winner of the last tie, so alternating ties give D, I, I, D.
  logic last_d;
  assign pick_d = d_valid && (!i_valid || !last_d);
  always_ff @(posedge clk) begin
    if (rst)
      last_d <= 1'b0;
    else if (accept && i_valid && d_valid)
      last_d <= pick_d;
  end
`else
  assign pick_d = d_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_ACCESS;
      S_ACCESS: if (count == 4'd0) state_next = S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    i_mem_status = ST_IDLE;
    d_mem_status = ST_IDLE;
    if (!rst) begin
      if (state == S_ACCESS && !grant_d)    i_mem_status = ST_BUSY;
      else if (state == S_DONE && !grant_d) i_mem_status = ST_DONE;
      else if (i_valid)                     i_mem_status = ST_BUSY;
      if (state == S_ACCESS && grant_d)     d_mem_status = ST_BUSY;
      else if (state == S_DONE && grant_d)  d_mem_status = ST_DONE;
      else if (d_valid)                     d_mem_status = ST_BUSY;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NBYTES; i++)
      rdata[i*BYTE_SIZE +: BYTE_SIZE] = mem[addr_q + ADDR_WIDTH'(i)];
  end

  always_comb begin
    case (type_q)
      3'b000:  wr_bytes = 1;
      3'b001:  wr_bytes = 2;
      default: wr_bytes = NBYTES;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 4'd0;
      grant_d    <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      type_q     <= 3'b000;
      wdata_q    <= '0;
      i_mem_data <= '0;
      d_mem_data <= '0;
    end else begin
      if (accept) begin
        count   <= 4'(LATENCY - 1);
        grant_d <= pick_d;
        addr_q  <= pick_d ? d_cache_mem_vis_addr : i_cache_mem_vis_addr;
        write_q <= pick_d && d_write;
        type_q  <= data_type;
        wdata_q <= written_data;
      end else if (state == S_ACCESS && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (op && !write_q) begin
        if (grant_d) d_mem_data <= rdata;
        else         i_mem_data <= rdata;
      end
    end
  end

  // Array has no reset so its contents survive rst; a reset edge during ACCESS suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && op && write_q) begin
      for (int i = 0; i < NBYTES; i++)
        if (i < wr_bytes)
          mem[addr_q + ADDR_WIDTH'(i)] <= wdata_q[i*BYTE_SIZE +: BYTE_SIZE];
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// tb/tb_main_memory_responder.sv - scoreboard bench for main_memory_responder
module tb_main_memory_responder;
  localparam int AW  = 17;
  localparam int DL  = 32;
  localparam int LAT = 2;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10;

  typedef struct {
    bit          is_d;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    i_sig = 2'b00;
  logic [AW-1:0] i_addr = '0;
  logic [1:0]    d_sig = 2'b00;
  logic [AW-1:0] d_addr = '0;
  logic [2:0]    dtype = 3'b010;
  logic [DL-1:0] wdata = '0;
  logic [DL-1:0] i_mem_data, d_mem_data;
  logic [1:0]    i_mem_status, d_mem_status;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_d_exp = '0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  main_memory_responder #(.ADDR_WIDTH(AW), .DATA_LEN(DL), .BYTE_SIZE(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_cache_mem_vis_signal(i_sig), .i_cache_mem_vis_addr(i_addr),
    .d_cache_mem_vis_signal(d_sig), .d_cache_mem_vis_addr(d_addr),
    .data_type(dtype), .written_data(wdata),
    .i_mem_data(i_mem_data), .i_mem_status(i_mem_status),
    .d_mem_data(d_mem_data), .d_mem_status(d_mem_status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input bit chk, input logic [31:0] data, input int cyc);
    exp_t e;
    e.is_d = is_d; e.chk = chk; e.data = data; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic on_done(input bit is_d, input logic [31:0] data, input int cyc);
    exp_t e;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("done_port", 32'(is_d), 32'(e.is_d));
    check("done_latency", 32'(cyc), 32'(e.cyc));
    if (e.chk) check(is_d ? "d_data" : "i_data", data, e.data);
  endtask

  // Drives requests at a negedge, then follows both ports until every request reaches DONE.
  task automatic run(input logic [1:0] isig, input logic [AW-1:0] ia,
                     input logic [1:0] dsig, input logic [AW-1:0] da,
                     input logic [2:0] dt, input logic [31:0] wd);
    int cyc;
    bit ip, dp, idrop, ddrop, bad;
    i_sig = isig; i_addr = ia; d_sig = dsig; d_addr = da; dtype = dt; wdata = wd;
    ip = (isig == 2'b01);
    dp = (dsig == 2'b01) || (dsig == 2'b10);
    cyc = 0; bad = 0; idrop = 0; ddrop = 0;
    while ((ip || dp) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (idrop) begin i_sig = 2'b00; idrop = 0; end
      if (ddrop) begin d_sig = 2'b00; ddrop = 0; end
      if (ip) begin
        if (i_mem_status === DONE) begin on_done(1'b0, i_mem_data, cyc); ip = 0; idrop = 1; end
        else if (i_mem_status !== BUSY) bad = 1;
      end
      if (dp) begin
        if (d_mem_status === DONE) begin on_done(1'b1, d_mem_data, cyc); dp = 0; ddrop = 1; end
        else if (d_mem_status !== BUSY) bad = 1;
      end
    end
    check("timeout", 32'(ip || dp), 32'd0);
    check("busy_while_pending", 32'(bad), 32'd0);
    @(negedge clk);
    i_sig = 2'b00; d_sig = 2'b00;
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic d_write(input logic [AW-1:0] a, input logic [2:0] t, input logic [31:0] d);
    push(1'b1, 1'b1, last_d_exp, LAT + 1);
    run(2'b00, '0, 2'b10, a, t, d);
  endtask

  task automatic d_read(input logic [AW-1:0] a, input logic [31:0] exp);
    push(1'b1, 1'b1, exp, LAT + 1);
    last_d_exp = exp;
    run(2'b00, '0, 2'b01, a, 3'b010, 32'h0);
  endtask

  task automatic i_read(input logic [AW-1:0] a, input logic [31:0] exp);
    push(1'b0, 1'b1, exp, LAT + 1);
    run(2'b01, a, 2'b00, '0, 3'b010, 32'h0);
  endtask

  task automatic tie_read(input logic [AW-1:0] ia, input logic [31:0] iexp,
                          input logic [AW-1:0] da, input logic [31:0] dexp, input bit d_first);
    if (d_first) begin
      push(1'b1, 1'b1, dexp, LAT + 1);
      push(1'b0, 1'b1, iexp, 2 * (LAT + 1) + 1);
    end else begin
      push(1'b0, 1'b1, iexp, LAT + 1);
      push(1'b1, 1'b1, dexp, 2 * (LAT + 1) + 1);
    end
    last_d_exp = dexp;
    run(2'b01, ia, 2'b01, da, 3'b010, 32'h0);
  endtask

  initial begin
    bit second_d_first;
    bit bad;
`ifdef MEM_RR_ARB_EN
    second_d_first = 1'b0;
`else
    second_d_first = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_i_status", 32'(i_mem_status), 32'(IDLE));
    check("rst_d_status", 32'(d_mem_status), 32'(IDLE));
    check("rst_i_data", i_mem_data, 32'h0);
    check("rst_d_data", d_mem_data, 32'h0);
    rst = 1'b0;

    i_sig = 2'b10; d_sig = 2'b11;
    repeat (3) @(negedge clk);
    check("none_code_i_status", 32'(i_mem_status), 32'(IDLE));
    check("none_code_d_status", 32'(d_mem_status), 32'(IDLE));
    i_sig = 2'b00; d_sig = 2'b00;
    @(negedge clk);

    d_write(17'h00010, 3'b010, 32'hDEADBEEF);
    d_read(17'h00010, 32'hDEADBEEF);
    d_write(17'h00011, 3'b000, 32'h123456AA);
    d_read(17'h00010, 32'hDEADAAEF);
    d_write(17'h00012, 3'b001, 32'h77665566);
    d_read(17'h00010, 32'h5566AAEF);
    d_write(17'h00020, 3'b111, 32'hA1B2C3D4);
    d_read(17'h00020, 32'hA1B2C3D4);
    i_read(17'h00020, 32'hA1B2C3D4);

    d_write(17'h00000, 3'b010, 32'hCAFEF00D);
    d_write(17'h1FFFE, 3'b010, 32'h11223344);
    d_read(17'h00000, 32'hCAFE1122);
    i_read(17'h1FFFE, 32'h11223344);
    d_read(17'h1FFFF, 32'hFE112233);

    d_write(17'h00100, 3'b010, 32'h01234567);
    d_write(17'h00200, 3'b010, 32'h89ABCDEF);
    tie_read(17'h00100, 32'h01234567, 17'h00200, 32'h89ABCDEF, 1'b1);
    tie_read(17'h00100, 32'h01234567, 17'h00200, 32'h89ABCDEF, second_d_first);

    d_sig = 2'b10; d_addr = 17'h00010; dtype = 3'b010; wdata = 32'h0BADF00D;
    @(negedge clk);
    check("access_busy", 32'(d_mem_status), 32'(BUSY));
    rst = 1'b1; d_sig = 2'b00;
    @(negedge clk);
    check("abort_i_status", 32'(i_mem_status), 32'(IDLE));
    check("abort_d_status", 32'(d_mem_status), 32'(IDLE));
    check("abort_i_data", i_mem_data, 32'h0);
    check("abort_d_data", d_mem_data, 32'h0);
    rst = 1'b0;
    last_d_exp = 32'h0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_mem_status !== IDLE) bad = 1;
    end
    check("no_done_after_abort", 32'(bad), 32'd0);
    d_read(17'h00010, 32'h5566AAEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
